// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================
// dmem_pkg : shared constants for the D-memory arbiter
// Revision : 1.0
// ============================================================
package dmem_pkg;

   localparam int DEFAULT_AWIDTH = 12;
   localparam int WAIT_W         = 8;

   typedef logic [0:0] state_t;
   localparam state_t CPU_PRI  = 1'b0;
   localparam state_t FORCE_P1 = 1'b1;

   typedef logic [0:0] port_id_t;
   localparam port_id_t PORT_CPU = 1'b0;
   localparam port_id_t PORT_DBG = 1'b1;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================
// dmem_arbiter : shares the single-port D-SRAM between the CPU
//                MEM stage (port 0) and a debug/DMA port (port 1)
// Revision     : 1.0
// ============================================================
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int AWIDTH   = DEFAULT_AWIDTH,
   parameter int MAX_WAIT = 8
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic              P0_REQ,
   input  logic              P0_WE,
   input  logic [3:0]        P0_BE,
   input  logic [AWIDTH-1:0] P0_ADDR,
   input  logic [31:0]       P0_WDATA,
   output logic              P0_GNT,
   output logic              P0_STALL,
   output logic              P0_RVALID,
   input  logic              P1_REQ,
   input  logic              P1_WE,
   input  logic [3:0]        P1_BE,
   input  logic [AWIDTH-1:0] P1_ADDR,
   input  logic [31:0]       P1_WDATA,
   output logic              P1_GNT,
   output logic              P1_RVALID,
   output logic [31:0]       RDATA,
   output logic              D_MEM_CSN,
   output logic              D_MEM_WEN,
   output logic [3:0]        D_MEM_BE,
   output logic [AWIDTH-1:0] D_MEM_ADDR,
   output logic [31:0]       D_MEM_DOUT,
   input  logic [31:0]       D_MEM_DI
);

   localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              rsp_valid_q, rsp_valid_d;
   port_id_t          rsp_owner_q, rsp_owner_d;
   logic              w_p0_gnt, w_p1_gnt;

   // ---------------- state register ----------------
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         state_q <= CPU_PRI;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         CPU_PRI: begin
            if (P1_REQ && (wait_cnt_q == MAX_WAIT_C)) begin
               state_d = FORCE_P1;
            end
         end
         default: state_d = CPU_PRI;
      endcase
   end

   // ---------------- grant outputs ----------------
   // FORCE_P1 lasts one cycle even if P1 has withdrawn; P0 stays denied.
   always_comb begin
      w_p0_gnt = 1'b0;
      w_p1_gnt = 1'b0;
      case (state_q)
         CPU_PRI: begin
            w_p0_gnt = P0_REQ;
            w_p1_gnt = P1_REQ & ~P0_REQ;
         end
         default: begin
            w_p1_gnt = P1_REQ;
         end
      endcase
   end

   assign P0_GNT   = w_p0_gnt;
   assign P1_GNT   = w_p1_gnt;
   assign P0_STALL = P0_REQ & ~w_p0_gnt;

   // ---------------- starvation counter and response tracking ----------------
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (w_p1_gnt || !P1_REQ) begin
         wait_cnt_d = '0;
      end else if (wait_cnt_q != MAX_WAIT_C) begin
         wait_cnt_d = wait_cnt_q + 1'b1;
      end
      rsp_valid_d = (w_p0_gnt & ~P0_WE) | (w_p1_gnt & ~P1_WE);
      rsp_owner_d = w_p1_gnt ? PORT_DBG : PORT_CPU;
   end

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         wait_cnt_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_owner_q <= PORT_CPU;
      end else begin
         wait_cnt_q  <= wait_cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_owner_q <= rsp_owner_d;
      end
   end

   assign P0_RVALID = rsp_valid_q & (rsp_owner_q == PORT_CPU);
   assign P1_RVALID = rsp_valid_q & (rsp_owner_q == PORT_DBG);
   assign RDATA     = D_MEM_DI;

   // ---------------- SRAM drive ----------------
   always_comb begin
      D_MEM_CSN  = 1'b1;
      D_MEM_WEN  = 1'b1;
      D_MEM_BE   = 4'h0;
      D_MEM_ADDR = '0;
      D_MEM_DOUT = 32'h0;
      if (w_p0_gnt) begin
         D_MEM_CSN  = 1'b0;
         D_MEM_WEN  = ~P0_WE;
         D_MEM_BE   = P0_BE;
         D_MEM_ADDR = P0_ADDR;
         D_MEM_DOUT = P0_WDATA;
      end else if (w_p1_gnt) begin
         D_MEM_CSN  = 1'b0;
         D_MEM_WEN  = ~P1_WE;
         D_MEM_BE   = P1_BE;
         D_MEM_ADDR = P1_ADDR;
         D_MEM_DOUT = P1_WDATA;
      end
   end

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================
// tb_dmem_arbiter : directed vectors and corner-case sequences
// Revision        : 1.0
// ============================================================
module tb_dmem_arbiter;

   localparam int AW = 12;

   logic          CLK = 1'b0;
   logic          RSTn;
   logic          P0_REQ, P0_WE, P1_REQ, P1_WE;
   logic [3:0]    P0_BE, P1_BE;
   logic [AW-1:0] P0_ADDR, P1_ADDR;
   logic [31:0]   P0_WDATA, P1_WDATA;
   logic          P0_GNT, P0_STALL, P0_RVALID, P1_GNT, P1_RVALID;
   logic [31:0]   RDATA;
   logic          D_MEM_CSN, D_MEM_WEN;
   logic [3:0]    D_MEM_BE;
   logic [AW-1:0] D_MEM_ADDR;
   logic [31:0]   D_MEM_DOUT, D_MEM_DI;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   dmem_arbiter #(.AWIDTH(AW), .MAX_WAIT(8)) dut (
      .CLK(CLK), .RSTn(RSTn),
      .P0_REQ(P0_REQ), .P0_WE(P0_WE), .P0_BE(P0_BE), .P0_ADDR(P0_ADDR),
      .P0_WDATA(P0_WDATA), .P0_GNT(P0_GNT), .P0_STALL(P0_STALL), .P0_RVALID(P0_RVALID),
      .P1_REQ(P1_REQ), .P1_WE(P1_WE), .P1_BE(P1_BE), .P1_ADDR(P1_ADDR),
      .P1_WDATA(P1_WDATA), .P1_GNT(P1_GNT), .P1_RVALID(P1_RVALID),
      .RDATA(RDATA),
      .D_MEM_CSN(D_MEM_CSN), .D_MEM_WEN(D_MEM_WEN), .D_MEM_BE(D_MEM_BE),
      .D_MEM_ADDR(D_MEM_ADDR), .D_MEM_DOUT(D_MEM_DOUT), .D_MEM_DI(D_MEM_DI)
   );

   // Single-port SRAM model: one-cycle read latency, byte-enabled writes.
   logic [31:0] mem [0:1023];
   logic [31:0] sram_q;
   logic        preload;
   always @(posedge CLK) begin
      if (preload) begin
         mem[1]  <= 32'h11110004;
         mem[2]  <= 32'h22220008;
         mem[4]  <= 32'h00000000;
         mem[64] <= 32'hCAFEF00D;
      end else if (!D_MEM_CSN) begin
         if (!D_MEM_WEN) begin
            for (int b = 0; b < 4; b++)
               if (D_MEM_BE[b]) mem[D_MEM_ADDR[AW-1:2]][8*b +: 8] <= D_MEM_DOUT[8*b +: 8];
         end else begin
            sram_q <= mem[D_MEM_ADDR[AW-1:2]];
         end
      end
   end
   assign D_MEM_DI = sram_q;

   typedef struct {
      logic          p0_req, p0_we;
      logic [3:0]    p0_be;
      logic [AW-1:0] p0_addr;
      logic [31:0]   p0_wdata;
      logic          p1_req, p1_we;
      logic [3:0]    p1_be;
      logic [AW-1:0] p1_addr;
      logic [31:0]   p1_wdata;
      logic          e_p0_gnt, e_p1_gnt, e_p0_stall, e_p0_rv, e_p1_rv;
      logic [31:0]   e_rdata;
      logic          e_csn, e_wen;
      logic [3:0]    e_be;
      logic [AW-1:0] e_addr;
      logic [31:0]   e_dout;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_reads(input logic r0, input logic [AW-1:0] a0,
                              input logic r1, input logic [AW-1:0] a1);
      P0_REQ = r0; P0_WE = 1'b0; P0_BE = 4'hF; P0_ADDR = a0; P0_WDATA = 32'h0;
      P1_REQ = r1; P1_WE = 1'b0; P1_BE = 4'hF; P1_ADDR = a1; P1_WDATA = 32'h0;
   endtask

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      logic exp_f, prev_f;

      vecs[0] = '{1'b0,1'b0,4'h0,12'h000,32'h0,        1'b0,1'b0,4'h0,12'h000,32'h0,
                  1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,4'h0,12'h000,32'h0};
      vecs[1] = '{1'b1,1'b1,4'hF,12'h010,32'hDEADBEEF, 1'b0,1'b0,4'h0,12'h000,32'h0,
                  1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,4'hF,12'h010,32'hDEADBEEF};
      vecs[2] = '{1'b1,1'b0,4'hF,12'h010,32'h0,        1'b0,1'b0,4'h0,12'h000,32'h0,
                  1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b1,4'hF,12'h010,32'h0};
      vecs[3] = '{1'b0,1'b0,4'h0,12'h000,32'h0,        1'b0,1'b0,4'h0,12'h000,32'h0,
                  1'b0,1'b0,1'b0,1'b1,1'b0,32'hDEADBEEF, 1'b1,1'b1,4'h0,12'h000,32'h0};
      vecs[4] = '{1'b0,1'b0,4'h0,12'h000,32'h0,        1'b1,1'b1,4'h3,12'h100,32'h12345678,
                  1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,4'h3,12'h100,32'h12345678};
      vecs[5] = '{1'b0,1'b0,4'h0,12'h000,32'h0,        1'b1,1'b0,4'hF,12'h100,32'h0,
                  1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b1,4'hF,12'h100,32'h0};
      vecs[6] = '{1'b0,1'b0,4'h0,12'h000,32'h0,        1'b0,1'b0,4'h0,12'h000,32'h0,
                  1'b0,1'b0,1'b0,1'b0,1'b1,32'hCAFE5678, 1'b1,1'b1,4'h0,12'h000,32'h0};
      vecs[7] = '{1'b1,1'b0,4'hF,12'h004,32'h0,        1'b1,1'b0,4'hF,12'h008,32'h0,
                  1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b1,4'hF,12'h004,32'h0};
      vecs[8] = '{1'b0,1'b0,4'h0,12'h000,32'h0,        1'b0,1'b0,4'h0,12'h000,32'h0,
                  1'b0,1'b0,1'b0,1'b1,1'b0,32'h11110004, 1'b1,1'b1,4'h0,12'h000,32'h0};

      // ---- reset ----
      RSTn = 1'b0; preload = 1'b1;
      drive_reads(1'b0, 12'h000, 1'b0, 12'h000);
      next_cycle();
      preload = 1'b0;
      next_cycle();
      @(negedge CLK);
      check("rst.p0_rv",  32'(P0_RVALID), 32'h0);
      check("rst.p1_rv",  32'(P1_RVALID), 32'h0);
      check("rst.csn",    32'(D_MEM_CSN), 32'h1);
      check("rst.wen",    32'(D_MEM_WEN), 32'h1);
      check("rst.wait",   32'(dut.wait_cnt_q), 32'h0);
      check("rst.state",  32'(dut.state_q), 32'h0);
      next_cycle();
      RSTn = 1'b1;

      // ---- table-driven single-port traffic ----
      for (int i = 0; i < 9; i++) begin
         P0_REQ = vecs[i].p0_req; P0_WE = vecs[i].p0_we; P0_BE = vecs[i].p0_be;
         P0_ADDR = vecs[i].p0_addr; P0_WDATA = vecs[i].p0_wdata;
         P1_REQ = vecs[i].p1_req; P1_WE = vecs[i].p1_we; P1_BE = vecs[i].p1_be;
         P1_ADDR = vecs[i].p1_addr; P1_WDATA = vecs[i].p1_wdata;
         @(negedge CLK);
         check($sformatf("v%0d.p0_gnt", i),   32'(P0_GNT),    32'(vecs[i].e_p0_gnt));
         check($sformatf("v%0d.p1_gnt", i),   32'(P1_GNT),    32'(vecs[i].e_p1_gnt));
         check($sformatf("v%0d.p0_stall", i), 32'(P0_STALL),  32'(vecs[i].e_p0_stall));
         check($sformatf("v%0d.p0_rv", i),    32'(P0_RVALID), 32'(vecs[i].e_p0_rv));
         check($sformatf("v%0d.p1_rv", i),    32'(P1_RVALID), 32'(vecs[i].e_p1_rv));
         if (vecs[i].e_p0_rv || vecs[i].e_p1_rv)
            check($sformatf("v%0d.rdata", i), RDATA, vecs[i].e_rdata);
         check($sformatf("v%0d.csn", i),      32'(D_MEM_CSN),  32'(vecs[i].e_csn));
         check($sformatf("v%0d.wen", i),      32'(D_MEM_WEN),  32'(vecs[i].e_wen));
         check($sformatf("v%0d.be", i),       32'(D_MEM_BE),   32'(vecs[i].e_be));
         check($sformatf("v%0d.addr", i),     32'(D_MEM_ADDR), 32'(vecs[i].e_addr));
         check($sformatf("v%0d.dout", i),     D_MEM_DOUT,      vecs[i].e_dout);
         next_cycle();
      end

      // ---- both ports reading continuously: forced P1 slot at cycles 9 and 19 ----
      prev_f = 1'b0;
      for (int c = 0; c < 21; c++) begin
         drive_reads(1'b1, 12'h004, 1'b1, 12'h008);
         exp_f = (c == 9) || (c == 19);
         @(negedge CLK);
         check($sformatf("cont%0d.p0_gnt", c), 32'(P0_GNT),   32'(!exp_f));
         check($sformatf("cont%0d.p1_gnt", c), 32'(P1_GNT),   32'(exp_f));
         check($sformatf("cont%0d.stall", c),  32'(P0_STALL), 32'(exp_f));
         check($sformatf("cont%0d.addr", c),   32'(D_MEM_ADDR), exp_f ? 32'h008 : 32'h004);
         check($sformatf("cont%0d.p0_rv", c),  32'(P0_RVALID), 32'((c > 0) && !prev_f));
         check($sformatf("cont%0d.p1_rv", c),  32'(P1_RVALID), 32'(prev_f));
         if (c > 0)
            check($sformatf("cont%0d.rdata", c), RDATA, prev_f ? 32'h22220008 : 32'h11110004);
         if (c == 8) check("cont8.wait", 32'(dut.wait_cnt_q), 32'h8);
         if (c == 9) check("cont9.state", 32'(dut.state_q), 32'h1);
         prev_f = exp_f;
         next_cycle();
      end
      drive_reads(1'b0, 12'h000, 1'b0, 12'h000);
      @(negedge CLK);
      check("cont_end.p0_rv", 32'(P0_RVALID), 32'h1);
      check("cont_end.p1_rv", 32'(P1_RVALID), 32'h0);
      check("cont_end.rdata", RDATA, 32'h11110004);
      next_cycle();

      // ---- reset pulse while a P0 read is granted and P1 is waiting ----
      for (int c = 0; c < 3; c++) begin
         drive_reads(1'b1, 12'h004, 1'b1, 12'h008);
         next_cycle();
      end
      RSTn = 1'b0;
      drive_reads(1'b1, 12'h004, 1'b1, 12'h008);
      @(negedge CLK);
      check("rstmid.wait_before", 32'(dut.wait_cnt_q), 32'h3);
      check("rstmid.p0_gnt",      32'(P0_GNT), 32'h1);
      next_cycle();
      RSTn = 1'b1;
      drive_reads(1'b0, 12'h000, 1'b0, 12'h000);
      @(negedge CLK);
      check("rstmid.p0_rv", 32'(P0_RVALID), 32'h0);
      check("rstmid.p1_rv", 32'(P1_RVALID), 32'h0);
      check("rstmid.wait",  32'(dut.wait_cnt_q), 32'h0);
      check("rstmid.csn",   32'(D_MEM_CSN), 32'h1);
      check("rstmid.wen",   32'(D_MEM_WEN), 32'h1);
      next_cycle();

      // ---- P1 withdraws in the cycle the forced slot begins ----
      for (int c = 0; c < 9; c++) begin
         drive_reads(1'b1, 12'h004, 1'b1, 12'h008);
         @(negedge CLK);
         if (c == 8) check("drop.wait8", 32'(dut.wait_cnt_q), 32'h8);
         next_cycle();
      end
      drive_reads(1'b1, 12'h004, 1'b0, 12'h008);
      @(negedge CLK);
      check("drop.state", 32'(dut.state_q), 32'h1);
      check("drop.p0_gnt", 32'(P0_GNT), 32'h0);
      check("drop.p1_gnt", 32'(P1_GNT), 32'h0);
      check("drop.stall",  32'(P0_STALL), 32'h1);
      check("drop.csn",    32'(D_MEM_CSN), 32'h1);
      next_cycle();
      @(negedge CLK);
      check("drop_next.p0_gnt", 32'(P0_GNT), 32'h1);
      check("drop_next.stall",  32'(P0_STALL), 32'h0);
      check("drop_next.wait",   32'(dut.wait_cnt_q), 32'h0);
      check("drop_next.state",  32'(dut.state_q), 32'h0);
      next_cycle();
      drive_reads(1'b0, 12'h000, 1'b0, 12'h000);
      next_cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_dmem_arbiter
`default_nettype wire
